mddr_io_bridge: RTL and testbench

//  Parametrised pad-side bridge between the mobile-DDR controller and the board memory pins.

---
 rtl/mddr_io_bridge_if.sv | 32 +++
 rtl/mddr_io_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_mddr_io_bridge.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mddr_io_bridge_if.sv
// Controller-side bundle of the mobile-DDR pad bridge: command/address, write
// beats, drive handshake and the captured read return path.
interface mddr_io_bridge_if #(
    parameter int DQ_WIDTH   = 16,
    parameter int ADDR_WIDTH = 13
) ();
    localparam int LANES = DQ_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] ctl_addr;
    logic [1:0]            ctl_ba;
    logic [LANES-1:0]      ctl_dm;
    logic [DQ_WIDTH-1:0]   ctl_dq_o;
    logic [LANES-1:0]      ctl_dqs_o;
    logic                  ctl_oe_req;
    logic                  ctl_oe_gnt;
    logic                  ctl_rd_en;
    logic [DQ_WIDTH-1:0]   ctl_dq_i;
    logic [LANES-1:0]      ctl_dqs_i;
    logic                  ctl_rd_valid;

    // Controller side
    modport master (
        output ctl_addr, ctl_ba, ctl_dm, ctl_dq_o, ctl_dqs_o, ctl_oe_req, ctl_rd_en,
        input  ctl_oe_gnt, ctl_dq_i, ctl_dqs_i, ctl_rd_valid
    );

    // Bridge side
    modport slave (
        input  ctl_addr, ctl_ba, ctl_dm, ctl_dq_o, ctl_dqs_o, ctl_oe_req, ctl_rd_en,
        output ctl_oe_gnt, ctl_dq_i, ctl_dqs_i, ctl_rd_valid
    );
endinterface

// File: rtl/mddr_io_bridge.sv
// Pad-side bridge between the mobile-DDR controller and the board memory pins.
// Registers command/address/mask, owns DQ/DQS direction through a guarded
// turnaround FSM, and returns read data through a fixed-latency capture pipe.
module mddr_io_bridge #(
    parameter int DQ_WIDTH       = 16,
    parameter int ADDR_WIDTH     = 13,
    parameter int PAD_ADDR_WIDTH = 14,
    parameter int TURN_CYCLES    = 1,
    parameter int RD_LATENCY     = 2,
    localparam int LANES         = DQ_WIDTH / 8
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    mddr_io_bridge_if.slave           ctl,
    output logic                      dir_err,
    output logic [PAD_ADDR_WIDTH-1:0] pad_addr,
    output logic [1:0]                pad_ba,
    output logic [LANES-1:0]          pad_dm,
    inout  wire  [DQ_WIDTH-1:0]       pad_dq,
    inout  wire  [LANES-1:0]          pad_dqs
);

    // Guard counter is loaded with one less than the guard length so that
    // exactly TURN_CYCLES hi-Z cycles elapse before the state moves on.
    localparam int         TURN_M1    = (TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0;
    localparam logic [3:0] TURN_LOAD  = TURN_M1[3:0];
    localparam bit         SKIP_GUARD = (TURN_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_HIZ     = 2'd0,
        ST_GUARD   = 2'd1,
        ST_DRIVE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [3:0]                cnt_r;
    logic [3:0]                cnt_nxt_s;
    logic                      oe_r;

    logic [PAD_ADDR_WIDTH-1:0] pad_addr_r;
    logic [PAD_ADDR_WIDTH-1:0] pad_addr_nxt_s;
    logic [1:0]                pad_ba_r;
    logic [LANES-1:0]          pad_dm_r;
    logic [DQ_WIDTH-1:0]       dq_out_r;
    logic [LANES-1:0]          dqs_out_r;

    logic [DQ_WIDTH-1:0]       tail_dq_s;
    logic [LANES-1:0]          tail_dqs_s;
    logic                      tail_en_s;
    logic                      rd_pending_s;
    logic [DQ_WIDTH-1:0]       rd_dq_r;
    logic [LANES-1:0]          rd_dqs_r;
    logic                      rd_valid_r;
    logic                      dir_err_r;

    // Zero-fill the unused upper address pins
    always_comb begin
        pad_addr_nxt_s                 = {PAD_ADDR_WIDTH{1'b0}};
        pad_addr_nxt_s[ADDR_WIDTH-1:0] = ctl.ctl_addr;
    end

    // Command/address/mask and write-data output registers
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            pad_addr_r <= {PAD_ADDR_WIDTH{1'b0}};
            pad_ba_r   <= 2'b00;
            pad_dm_r   <= {LANES{1'b1}};
            dq_out_r   <= {DQ_WIDTH{1'b0}};
            dqs_out_r  <= {LANES{1'b0}};
        end else begin
            pad_addr_r <= pad_addr_nxt_s;
            pad_ba_r   <= ctl.ctl_ba;
            pad_dm_r   <= ctl.ctl_dm;
            dq_out_r   <= ctl.ctl_dq_o;
            dqs_out_r  <= ctl.ctl_dqs_o;
        end
    end

    // Turnaround FSM next-state: a drive request only leaves HIZ once no
    // read is in flight and no read is being issued in the same cycle
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_HIZ: begin
                if (ctl.ctl_oe_req && !rd_pending_s && !ctl.ctl_rd_en) begin
                    if (SKIP_GUARD) begin
                        state_nxt_s = ST_DRIVE;
                    end else begin
                        state_nxt_s = ST_GUARD;
                        cnt_nxt_s   = TURN_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_HIZ;
                end
            end
            ST_GUARD: begin
                if (!ctl.ctl_oe_req) begin
                    state_nxt_s = ST_HIZ;
                end else if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_DRIVE;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_DRIVE: begin
                if (!ctl.ctl_oe_req) begin
                    if (SKIP_GUARD) begin
                        state_nxt_s = ST_HIZ;
                    end else begin
                        state_nxt_s = ST_RELEASE;
                        cnt_nxt_s   = TURN_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_DRIVE;
                end
            end
            ST_RELEASE: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_HIZ;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_HIZ;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Turnaround FSM state, guard counter and registered drive enable
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_r <= ST_HIZ;
            cnt_r   <= 4'd0;
            oe_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            oe_r    <= (state_nxt_s == ST_DRIVE);
        end
    end

    generate
        if (RD_LATENCY > 1) begin : g_pipe
            logic [DQ_WIDTH-1:0] dq_pipe_r  [RD_LATENCY-1];
            logic [LANES-1:0]    dqs_pipe_r [RD_LATENCY-1];
            logic [RD_LATENCY-2:0] en_pipe_r;

            // Capture register plus intermediate stages, rd_en shifted alongside
            always_ff @(posedge clk_clk) begin
                if (!reset_reset_n) begin
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        dq_pipe_r[i]  <= {DQ_WIDTH{1'b0}};
                        dqs_pipe_r[i] <= {LANES{1'b0}};
                    end
                    en_pipe_r <= {(RD_LATENCY-1){1'b0}};
                end else begin
                    dq_pipe_r[0]  <= pad_dq;
                    dqs_pipe_r[0] <= pad_dqs;
                    en_pipe_r[0]  <= ctl.ctl_rd_en;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        dq_pipe_r[i]  <= dq_pipe_r[i-1];
                        dqs_pipe_r[i] <= dqs_pipe_r[i-1];
                        en_pipe_r[i]  <= en_pipe_r[i-1];
                    end
                end
            end

            assign tail_dq_s    = dq_pipe_r[RD_LATENCY-2];
            assign tail_dqs_s   = dqs_pipe_r[RD_LATENCY-2];
            assign tail_en_s    = en_pipe_r[RD_LATENCY-2];
            assign rd_pending_s = |en_pipe_r;
        end else begin : g_direct
            assign tail_dq_s    = pad_dq;
            assign tail_dqs_s   = pad_dqs;
            assign tail_en_s    = ctl.ctl_rd_en;
            assign rd_pending_s = 1'b0;
        end
    endgenerate

    // Final read stage: loads only on a valid beat so data holds in between;
    // a capture while the bridge drives the pads is flagged sticky
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rd_dq_r    <= {DQ_WIDTH{1'b0}};
            rd_dqs_r   <= {LANES{1'b0}};
            rd_valid_r <= 1'b0;
            dir_err_r  <= 1'b0;
        end else begin
            rd_valid_r <= tail_en_s;
            if (tail_en_s) begin
                rd_dq_r  <= tail_dq_s;
                rd_dqs_r <= tail_dqs_s;
            end else begin
                rd_dq_r  <= rd_dq_r;
                rd_dqs_r <= rd_dqs_r;
            end
            if (ctl.ctl_rd_en && oe_r) begin
                dir_err_r <= 1'b1;
            end else begin
                dir_err_r <= dir_err_r;
            end
        end
    end

    assign pad_dq           = oe_r ? dq_out_r  : {DQ_WIDTH{1'bz}};
    assign pad_dqs          = oe_r ? dqs_out_r : {LANES{1'bz}};
    assign pad_addr         = pad_addr_r;
    assign pad_ba           = pad_ba_r;
    assign pad_dm           = pad_dm_r;
    assign dir_err          = dir_err_r;
    assign ctl.ctl_oe_gnt   = oe_r;
    assign ctl.ctl_dq_i     = rd_dq_r;
    assign ctl.ctl_dqs_i    = rd_dqs_r;
    assign ctl.ctl_rd_valid = rd_valid_r;

endmodule

// File: tb/tb_mddr_io_bridge.sv
// Directed bench for mddr_io_bridge with default parameters. Read beats are
// checked by a scoreboard/monitor pair; pad and handshake state by direct checks.
module tb_mddr_io_bridge;

    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dir_err;
    logic [13:0] pad_addr;
    logic [1:0]  pad_ba;
    logic [1:0]  pad_dm;
    wire  [15:0] pad_dq;
    wire  [1:0]  pad_dqs;

    logic        tb_drv;
    logic [15:0] tb_dq;
    logic [1:0]  tb_dqs;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    typedef struct {
        logic [15:0] dq;
        logic [1:0]  dqs;
        int          due;
    } rd_exp_t;

    rd_exp_t sb[$];

    mddr_io_bridge_if #(.DQ_WIDTH(16), .ADDR_WIDTH(13)) ctl_if ();

    mddr_io_bridge #(
        .DQ_WIDTH(16), .ADDR_WIDTH(13), .PAD_ADDR_WIDTH(14),
        .TURN_CYCLES(1), .RD_LATENCY(RDL)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .ctl           (ctl_if),
        .dir_err       (dir_err),
        .pad_addr      (pad_addr),
        .pad_ba        (pad_ba),
        .pad_dm        (pad_dm),
        .pad_dq        (pad_dq),
        .pad_dqs       (pad_dqs)
    );

    assign pad_dq  = tb_drv ? tb_dq  : 16'hzzzz;
    assign pad_dqs = tb_drv ? tb_dqs : 2'bzz;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [15:0] dq, input logic [1:0] dqs);
        rd_exp_t e;
        e.dq  = dq;
        e.dqs = dqs;
        e.due = cyc_cnt + RDL;
        sb.push_back(e);
    endtask

    // Monitor: every valid beat must match the head of the scoreboard
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (ctl_if.ctl_rd_valid) begin
                if (sb.size() == 0) begin
                    chk("rd_valid_unexpected", {31'b0, ctl_if.ctl_rd_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_cycle", cyc_cnt, e.due);
                    chk("rd_dq", {16'b0, ctl_if.ctl_dq_i}, {16'b0, e.dq});
                    chk("rd_dqs", {30'b0, ctl_if.ctl_dqs_i}, {30'b0, e.dqs});
                end
            end else if (sb.size() > 0 && sb[0].due < cyc_cnt) begin
                chk("rd_valid_due", {31'b0, ctl_if.ctl_rd_valid}, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        tb_drv            = 1'b0;
        tb_dq             = 16'h0000;
        tb_dqs            = 2'b00;
        ctl_if.ctl_addr   = 13'h0;
        ctl_if.ctl_ba     = 2'b00;
        ctl_if.ctl_dm     = 2'b00;
        ctl_if.ctl_dq_o   = 16'h0000;
        ctl_if.ctl_dqs_o  = 2'b00;
        ctl_if.ctl_oe_req = 1'b0;
        ctl_if.ctl_rd_en  = 1'b0;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_gnt", {31'b0, ctl_if.ctl_oe_gnt}, 32'd0);
        chk("rst_dir_err", {31'b0, dir_err}, 32'd0);
        chk("rst_pad_addr", {18'b0, pad_addr}, 32'h0);
        chk("rst_pad_ba", {30'b0, pad_ba}, 32'h0);
        chk("rst_pad_dm", {30'b0, pad_dm}, 32'h3);
        chk("rst_rd_valid", {31'b0, ctl_if.ctl_rd_valid}, 32'd0);
        chk("rst_dq_i", {16'b0, ctl_if.ctl_dq_i}, 32'h0);
        rst_n = 1'b1;
        step();

        // Address / bank / mask path
        ctl_if.ctl_addr = 13'h1ABC;
        ctl_if.ctl_ba   = 2'b10;
        ctl_if.ctl_dm   = 2'b01;
        step();
        @(negedge clk);
        chk("addr_1abc", {18'b0, pad_addr}, 32'h1ABC);
        chk("pad_ba", {30'b0, pad_ba}, 32'h2);
        chk("pad_dm", {30'b0, pad_dm}, 32'h1);
        ctl_if.ctl_addr = 13'h1FFF;
        step();
        @(negedge clk);
        chk("addr_1fff", {18'b0, pad_addr}, 32'h1FFF);
        chk("addr_msb_zero", {31'b0, pad_addr[13]}, 32'd0);

        // Back-to-back reads
        tb_drv = 1'b1; tb_dq = 16'h1234; tb_dqs = 2'b01;
        ctl_if.ctl_rd_en = 1'b1;
        push_rd(16'h1234, 2'b01);
        step();
        tb_dq = 16'h5678; tb_dqs = 2'b10;
        push_rd(16'h5678, 2'b10);
        step();
        ctl_if.ctl_rd_en = 1'b0;
        tb_drv = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("rd_hold", {16'b0, ctl_if.ctl_dq_i}, 32'h5678);

        // Write burst with one guard cycle each side
        ctl_if.ctl_oe_req = 1'b1;
        step();
        @(negedge clk);
        chk("wr_guard_gnt", {31'b0, ctl_if.ctl_oe_gnt}, 32'd0);
        step();
        @(negedge clk);
        chk("wr_gnt", {31'b0, ctl_if.ctl_oe_gnt}, 32'd1);
        ctl_if.ctl_dq_o  = 16'hA5C3;
        ctl_if.ctl_dqs_o = 2'b11;
        step();
        @(negedge clk);
        chk("wr_pad_dq", {16'b0, pad_dq}, 32'hA5C3);
        chk("wr_pad_dqs", {30'b0, pad_dqs}, 32'h3);
        ctl_if.ctl_oe_req = 1'b0;
        step();
        @(negedge clk);
        chk("wr_release_gnt", {31'b0, ctl_if.ctl_oe_gnt}, 32'd0);
        step();

        // Request dropped during guard aborts the grant
        ctl_if.ctl_oe_req = 1'b1;
        step();
        ctl_if.ctl_oe_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("guard_abort_gnt", {31'b0, ctl_if.ctl_oe_gnt}, 32'd0);
        end

        // Read and drive request in the same cycle: read wins
        tb_drv = 1'b1; tb_dq = 16'hBEEF; tb_dqs = 2'b11;
        ctl_if.ctl_rd_en  = 1'b1;
        ctl_if.ctl_oe_req = 1'b1;
        push_rd(16'hBEEF, 2'b11);
        step();
        ctl_if.ctl_rd_en = 1'b0;
        tb_drv = 1'b0;
        @(negedge clk);
        chk("turn_wait", {31'b0, ctl_if.ctl_oe_gnt}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            chk("turn_wait", {31'b0, ctl_if.ctl_oe_gnt}, 32'd0);
        end
        step();
        @(negedge clk);
        chk("turn_gnt", {31'b0, ctl_if.ctl_oe_gnt}, 32'd1);

        // Capture while driving: own data returns, dir_err sticks
        ctl_if.ctl_dq_o  = 16'h0F0F;
        ctl_if.ctl_dqs_o = 2'b10;
        step();
        ctl_if.ctl_rd_en = 1'b1;
        push_rd(16'h0F0F, 2'b10);
        @(negedge clk);
        chk("dir_err_before", {31'b0, dir_err}, 32'd0);
        step();
        ctl_if.ctl_rd_en = 1'b0;
        @(negedge clk);
        chk("dir_err_set", {31'b0, dir_err}, 32'd1);
        repeat (2) step();
        @(negedge clk);
        chk("dir_err_sticky", {31'b0, dir_err}, 32'd1);

        // Reset while driving releases the pads at once
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("rst_drive_gnt", {31'b0, ctl_if.ctl_oe_gnt}, 32'd0);
        chk("rst_drive_dir_err", {31'b0, dir_err}, 32'd0);
        ctl_if.ctl_oe_req = 1'b0;
        rst_n = 1'b1;
        step();

        // Pads are free again: an external value is captured intact
        tb_drv = 1'b1; tb_dq = 16'hC0DE; tb_dqs = 2'b01;
        ctl_if.ctl_rd_en = 1'b1;
        push_rd(16'hC0DE, 2'b01);
        step();
        ctl_if.ctl_rd_en = 1'b0;
        tb_drv = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("post_rst_hold", {16'b0, ctl_if.ctl_dq_i}, 32'hC0DE);
        chk("sb_drain", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
